upsample_ctrl: RTL and testbench
================================

UPSAMPLE_CTRL -- requirements
Module: upsample_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter LINE_W, default 640, meaning input pixels per line (minimum 2).
REQ-003 The block SHALL have parameter FRAME_H, default 480, meaning input lines per frame (minimum 1).
REQ-004 The block SHALL have port clock  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  meaning begin a frame when idle.
REQ-007 The block SHALL have port valid  input  1  meaning FIFO read data valid, one cycle after fifo_read.
REQ-008 The block SHALL have port data  input  DW  meaning FIFO read data.
REQ-009 The block SHALL have port fifo_read  output  1  meaning FIFO read-enable pulse.
REQ-010 The block SHALL have port dout_ready  input  1  meaning downstream accepts dataout.
REQ-011 The block SHALL have port dataout  output  DW  meaning upsampled pixel.
REQ-012 The block SHALL have port validout  output  1  meaning dataout is valid.
REQ-013 The block SHALL have port busy  output  1  meaning the state is not IDLE.
REQ-014 The block SHALL have port frame_done  output  1  meaning a one-cycle pulse after the last output pixel of a frame.

Function
REQ-015 The block SHALL sequence 2x nearest-neighbour upsampling: each input pixel is emitted twice horizontally, and each line is emitted twice vertically.
REQ-016 The block SHALL implement the states IDLE, REQ, WAIT, EMIT_A, EMIT_B, RPL_LD, RPL_A, RPL_B, DONE.
REQ-017 IDLE SHALL go to REQ when start=1, with col=0 and row=0.
REQ-018 REQ SHALL assert fifo_read for exactly one cycle, then go to WAIT.
REQ-019 WAIT SHALL, when valid=1, capture data into the pixel register and line buffer[col] and go to EMIT_A; when valid=0 it SHALL return to REQ (retry on empty FIFO).
REQ-020 EMIT_A and EMIT_B SHALL drive validout=1 and dataout from the pixel register, and each SHALL advance only on dout_ready=1.
REQ-021 From EMIT_B, col<LINE_W-1 SHALL increment col and go to REQ; col=LINE_W-1 SHALL clear col and go to RPL_LD.
REQ-022 RPL_LD SHALL load buffer[col] into the pixel register (one-cycle buffer read), then go to RPL_A.
REQ-023 RPL_A and RPL_B SHALL behave as EMIT_A and EMIT_B.
REQ-024 From RPL_B, col<LINE_W-1 SHALL increment col and go to RPL_LD; otherwise it SHALL clear col.
REQ-025 When RPL_B ends a line with row<FRAME_H-1, the block SHALL increment row and go to REQ; with row=FRAME_H-1 it SHALL go to DONE.
REQ-026 DONE SHALL assert frame_done for one cycle and go to IDLE.
REQ-027 Latency from valid capture to first validout SHALL be 1 cycle.
REQ-028 dataout SHALL hold stable while validout=1 and dout_ready=0.
REQ-029 valid SHALL be ignored in every state except WAIT.
REQ-030 start SHALL be ignored in every state except IDLE.
REQ-031 col and row SHALL be $clog2-sized counters compared with equality only, with no wrap beyond LINE_W-1 or FRAME_H-1.
REQ-032 fifo_read SHALL never be asserted while validout=1.
REQ-033 At most one FIFO read SHALL be outstanding.

Reset
REQ-034 reset=1 SHALL force at the next edge: state=IDLE, col=0, row=0, fifo_read=0, validout=0, dataout=0, busy=0, frame_done=0.
REQ-035 Reset mid-frame SHALL abandon the frame with no frame_done pulse, and FIFO data returned after reset SHALL be discarded.
REQ-036 Line buffer contents SHALL not be cleared by reset.

Configuration
REQ-037 The macro UPSAMPLE_CTRL_VDUP_EN SHALL control vertical duplication.
REQ-038 With UPSAMPLE_CTRL_VDUP_EN defined, the block SHALL behave per REQ-021..REQ-025 and include the LINE_W x DW line buffer.
REQ-039 With UPSAMPLE_CTRL_VDUP_EN undefined, the block SHALL omit the line buffer and states RPL_*; EMIT_B at col=LINE_W-1 SHALL go directly to the row check of REQ-025, giving horizontal-only 2x output.

Verification
REQ-040 The bench SHALL run LINE_W=4, FRAME_H=2, VDUP_EN on, FIFO values 1..8, dout_ready=1: dataout must be 1,1,2,2,3,3,4,4 twice, then 5,5..8,8 twice (32 beats), then frame_done once.
REQ-041 The bench SHALL drive valid=0 for the first 3 reads, then value 9: fifo_read must pulse 4 times, and the first output must be 9,9.
REQ-042 The bench SHALL hold dout_ready=0 for 5 cycles during EMIT_A: validout=1 with dataout stable for all 5 cycles, and fifo_read=0.
REQ-043 The bench SHALL assert reset at the 10th output beat: the next cycle shows validout=0 and busy=0; a new start must restart at row 0 with fresh FIFO data.
REQ-044 The bench SHALL repeat REQ-040 with VDUP_EN undefined: 16 beats 1,1..8,8 in order, then frame_done.
REQ-045 The bench SHALL pulse start while busy: there must be no effect, and the frame must complete with exactly 32 beats.

Source files
------------

// File: rtl/upsample_ctrl.sv
// 2x nearest-neighbour upsampling sequencer: pulls pixels from a FIFO and emits each twice.
// Define UPSAMPLE_CTRL_VDUP_EN for vertical line duplication through a line buffer.
module upsample_ctrl #(
  parameter int unsigned DW      = 8,
  parameter int unsigned LINE_W  = 640,
  parameter int unsigned FRAME_H = 480
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          valid,
  input  logic [DW-1:0] data,
  output logic          fifo_read,
  input  logic          dout_ready,
  output logic [DW-1:0] dataout,
  output logic          validout,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - 1);

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    WAIT,
    EMIT_A,
    EMIT_B,
    DONE
`ifdef UPSAMPLE_CTRL_VDUP_EN
    ,
    RPL_LD,
    RPL_A,
    RPL_B
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [DW-1:0]    pix_d;
  logic             emit_d;

`ifdef UPSAMPLE_CTRL_VDUP_EN
  logic          buf_we;
  logic [DW-1:0] line_buf [LINE_W];

  // Line buffer keeps the captured line for the repeated pass; never cleared.
  always_ff @(posedge clock) begin
    if (buf_we) line_buf[col_q] <= data;
  end
`endif

  // Next-state, counter and pixel-register logic.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pix_d   = dataout;
`ifdef UPSAMPLE_CTRL_VDUP_EN
    buf_we  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          col_d   = '0;
          row_d   = '0;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (valid) begin
          pix_d   = data;
          state_d = EMIT_A;
`ifdef UPSAMPLE_CTRL_VDUP_EN
          buf_we  = 1'b1;
`endif
        end else begin
          state_d = REQ;
        end
      end
      EMIT_A: begin
        if (dout_ready) state_d = EMIT_B;
      end
      EMIT_B: begin
        if (dout_ready) begin
          if (col_q != COL_LAST) begin
            col_d   = col_q + COL_W'(1);
            state_d = REQ;
          end else begin
            col_d = '0;
`ifdef UPSAMPLE_CTRL_VDUP_EN
            state_d = RPL_LD;
`else
            if (row_q != ROW_LAST) begin
              row_d   = row_q + ROW_W'(1);
              state_d = REQ;
            end else begin
              state_d = DONE;
            end
`endif
          end
        end
      end
`ifdef UPSAMPLE_CTRL_VDUP_EN
      RPL_LD: begin
        pix_d   = line_buf[col_q];
        state_d = RPL_A;
      end
      RPL_A: begin
        if (dout_ready) state_d = RPL_B;
      end
      RPL_B: begin
        if (dout_ready) begin
          if (col_q != COL_LAST) begin
            col_d   = col_q + COL_W'(1);
            state_d = RPL_LD;
          end else begin
            col_d = '0;
            if (row_q != ROW_LAST) begin
              row_d   = row_q + ROW_W'(1);
              state_d = REQ;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Emit states drive validout.
  always_comb begin
    emit_d = (state_d == EMIT_A) || (state_d == EMIT_B);
`ifdef UPSAMPLE_CTRL_VDUP_EN
    if ((state_d == RPL_A) || (state_d == RPL_B)) emit_d = 1'b1;
`endif
  end

  // State register; outputs are registered decodes of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      dataout    <= '0;
      fifo_read  <= 1'b0;
      validout   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      dataout    <= pix_d;
      fifo_read  <= (state_d == REQ);
      validout   <= emit_d;
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_upsample_ctrl.sv
// Randomized self-checking bench for upsample_ctrl against a frame-level reference model.
// Expected beat count follows UPSAMPLE_CTRL_VDUP_EN as seen by this compile.
module tb_upsample_ctrl;

  localparam int W = 4;
  localparam int H = 2;
`ifdef UPSAMPLE_CTRL_VDUP_EN
  localparam int REPS = 2;
`else
  localparam int REPS = 1;
`endif
  localparam int EXP_BEATS = W * H * 2 * REPS;
  localparam int BUDGET    = 3000;

  logic       clock = 1'b0;
  logic       reset, start, valid, dout_ready;
  logic [7:0] data;
  logic       fifo_read, validout, busy, frame_done;
  logic [7:0] dataout;

  upsample_ctrl #(.DW(8), .LINE_W(W), .FRAME_H(H)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .valid     (valid),
    .data      (data),
    .fifo_read (fifo_read),
    .dout_ready(dout_ready),
    .dataout   (dataout),
    .validout  (validout),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] pix_q [$];
  logic [7:0] exp_q [$];
  int  beat_cnt, rd_cnt, done_cnt, first_rd, proto_err, empty_cnt, hold_cnt;
  bit  rd_pend, junk, start_req, poke_start, rnd_ready, rnd_empty, arm_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe outputs, model the FIFO and the downstream sink.
  task automatic tick();
    @(negedge clock);
    if (fifo_read && validout) proto_err++;
    if (fifo_read && rd_pend) proto_err++;
    if (frame_done) done_cnt++;

    start     = start_req || (poke_start && busy && ($urandom_range(0, 3) == 0));
    start_req = 1'b0;

    valid = 1'b0;
    data  = 8'($urandom);
    if (junk) begin
      valid = 1'b1;
    end else if (rd_pend) begin
      if (empty_cnt > 0) empty_cnt--;
      else if (rnd_empty && ($urandom_range(0, 3) == 0)) valid = 1'b0;
      else if (pix_q.size() > 0) begin
        valid = 1'b1;
        data  = pix_q.pop_front();
      end
    end else if (rnd_empty && ($urandom_range(0, 3) == 0)) begin
      valid = 1'b1;
    end
    rd_pend = fifo_read;
    if (fifo_read) rd_cnt++;

    if (arm_hold && validout) begin
      arm_hold = 1'b0;
      hold_cnt = 5;
    end
    if (hold_cnt > 0) begin
      hold_cnt--;
      dout_ready = 1'b0;
      check("hold_validout", 32'(validout), 1);
      check("hold_dataout", 32'(dataout), 32'(exp_q[0]));
      check("hold_fifo_read", 32'(fifo_read), 0);
    end else begin
      dout_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    if (validout && dout_ready) begin
      beat_cnt++;
      if (beat_cnt == 1) first_rd = rd_cnt;
      if (exp_q.size() > 0) check("beat", 32'(dataout), 32'(exp_q.pop_front()));
    end
  endtask

  // Build a frame, its expected output stream, and run it to frame_done.
  task automatic run_frame(input int base, input bit rnd_px, input int n_empty, input bit rnd_rdy,
                           input bit rnd_emp, input bit poke, input bit hold, input int abort_at);
    logic [7:0] px [$];
    int cyc;
    px.delete();
    pix_q.delete();
    exp_q.delete();
    for (int i = 0; i < W * H; i++) px.push_back(rnd_px ? 8'($urandom) : 8'(base + i));
    pix_q = px;
    for (int r = 0; r < H; r++)
      for (int rep = 0; rep < REPS; rep++)
        for (int c = 0; c < W; c++) begin
          exp_q.push_back(px[r * W + c]);
          exp_q.push_back(px[r * W + c]);
        end
    beat_cnt = 0; rd_cnt = 0; done_cnt = 0; first_rd = 0; proto_err = 0; hold_cnt = 0;
    empty_cnt = n_empty; rnd_ready = rnd_rdy; rnd_empty = rnd_emp;
    poke_start = poke; arm_hold = hold; start_req = 1'b1;
    cyc = 0;
    while (done_cnt == 0 && cyc < BUDGET) begin
      tick();
      cyc++;
      if (abort_at != 0 && beat_cnt == abort_at) return;
    end
    poke_start = 1'b0;
    repeat (3) tick();
    check("beats", 32'(beat_cnt), 32'(EXP_BEATS));
    check("frame_done_cnt", 32'(done_cnt), 1);
    check("protocol", 32'(proto_err), 0);
    check("fifo_left", 32'(pix_q.size()), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; data = '0; dout_ready = 1'b1;
    rd_pend = 1'b0; junk = 1'b0; start_req = 1'b0; poke_start = 1'b0;
    rnd_ready = 1'b0; rnd_empty = 1'b0; arm_hold = 1'b0;
    beat_cnt = 0; rd_cnt = 0; done_cnt = 0; first_rd = 0; proto_err = 0;
    empty_cnt = 0; hold_cnt = 0;
    repeat (2) tick();
    check("rst_validout", 32'(validout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fifo_read", 32'(fifo_read), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_dataout", 32'(dataout), 0);
    reset = 1'b0;
    tick();

    // Plain frame, values 1..8, sink always ready.
    run_frame(1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Three empty reads before the first pixel.
    run_frame(9, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("reads_first_px", 32'(first_rd), 4);
    check("reads_total", 32'(rd_cnt), 32'(W * H + 3));

    // Backpressure on the first beat.
    run_frame(20, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Start pulses while busy must be ignored.
    run_frame(40, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Reset on the 10th beat, stray FIFO data afterwards, then a fresh frame.
    run_frame(60, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    reset = 1'b1;
    junk  = 1'b1;
    tick();
    check("abort_validout", 32'(validout), 0);
    check("abort_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (4) tick();
    check("abort_no_done", 32'(done_cnt), 0);
    check("abort_stay_idle", 32'(busy), 0);
    check("abort_no_read", 32'(fifo_read), 0);
    junk    = 1'b0;
    rd_pend = 1'b0;
    tick();
    run_frame(100, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Random pixels, random sink stalls, random empty reads and stray valids.
    for (int k = 0; k < 4; k++) run_frame(0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
